// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle datapath and its controller.
// The datapath (master) supplies the instruction register and ALU flags;
// the controller (slave) returns write enables, mux selects and debug state.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;
  logic        IllegalInstr;
  logic [3:0]  State;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  ImmSrc, RegSrc, ALUControl, IllegalInstr, State
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output ImmSrc, RegSrc, ALUControl, IllegalInstr, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: one FSM sequences fetch/decode/execute,
// holds the NZCV flags and the condition result latched at decode, and gates
// every architectural write by that condition.
module multicycle_controller (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e      state_q;
  logic [3:0]  flags_q;
  logic        condex_q;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic [3:0]  rd;
  logic        unused_instr;

  assign cond         = bus.Instr[31:28];
  assign op           = bus.Instr[27:26];
  assign i_bit        = bus.Instr[25];
  assign cmd          = bus.Instr[24:21];
  assign s_bit        = bus.Instr[20];
  assign rd           = bus.Instr[15:12];
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

  logic        cond_ex;
  logic        legal_dp;
  logic        is_cmp;
  logic        is_arith;
  logic [1:0]  dp_alu;

  // Evaluate the condition field against the stored NZCV flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Decode the data-processing command into an ALU operation and legality.
  always_comb begin
    legal_dp = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b0;
    dp_alu   = 2'b00;
    case (cmd)
      4'b0100: begin dp_alu = 2'b00; is_arith = 1'b1; end
      4'b0010: begin dp_alu = 2'b01; is_arith = 1'b1; end
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin dp_alu = 2'b01; is_cmp = 1'b1; end
      default: legal_dp = 1'b0;
    endcase
  end

  // Sequence the instruction phases and update condition/flag state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          condex_q <= cond_ex;
          case (op)
            2'b01:   state_q <= StMemAdr;
            2'b00:   state_q <= !legal_dp ? StFetch : (i_bit ? StExecI : StExecR);
            2'b10:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= s_bit ? StMemRd : StMemWr;
        StMemRd:  state_q <= StMemWb;
        StExecR, StExecI: begin
          state_q <= StAluWb;
          if (condex_q) begin
            if (s_bit || is_cmp) flags_q[3:2] <= bus.ALUFlags[3:2];
            if ((s_bit && is_arith) || is_cmp) flags_q[1:0] <= bus.ALUFlags[1:0];
          end
        end
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic regw_req;
  logic memw_req;
  logic branch_req;

  // Drive mux selects and gated write enables from the current state.
  always_comb begin
    regw_req         = 1'b0;
    memw_req         = 1'b0;
    branch_req       = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ResultSrc    = 2'b00;
    bus.ALUControl   = 2'b00;
    bus.IllegalInstr = 1'b0;
    case (state_q)
      StFetch: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      StDecode: begin
        bus.ALUSrcA      = 1'b1;
        bus.ALUSrcB      = 2'b10;
        bus.ResultSrc    = 2'b10;
        bus.IllegalInstr = (op == 2'b11) || ((op == 2'b00) && !legal_dp);
      end
      StMemAdr: bus.ALUSrcB = 2'b01;
      StMemRd:  bus.AdrSrc = 1'b1;
      StMemWb: begin
        bus.ResultSrc = 2'b01;
        regw_req      = 1'b1;
      end
      StMemWr: begin
        bus.AdrSrc = 1'b1;
        memw_req   = 1'b1;
      end
      StExecR:  bus.ALUControl = dp_alu;
      StExecI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = dp_alu;
      end
      StAluWb:  regw_req = !is_cmp;
      StBranch: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        branch_req    = 1'b1;
      end
      default: ;
    endcase
    bus.RegWrite = regw_req & condex_q;
    bus.MemWrite = memw_req & condex_q;
    // A register write to R15 is a PC write.
    bus.PCWrite  = (state_q == StFetch) |
                   (condex_q & (branch_req | (regw_req & (rd == 4'd15))));
  end

  assign bus.ImmSrc = op;
  assign bus.RegSrc = {op == 2'b01, op == 2'b10};
  assign bus.State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model predicts the
// per-cycle outputs of each instruction; a negedge process compares them.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr, srca;
    logic [1:0] srcb, res, imm, regsrc, aluc;
    logic       ill;
  } outs_t;

  int          checks = 0;
  int          errs   = 0;
  logic        check_en = 1'b0;
  outs_t       exp_o;
  logic [31:0] cur_ins;
  int          cur_step;
  logic [3:0]  mflags;
  int          model_len;

  logic [3:0] tr_st[$];
  logic       tr_pcw[$], tr_rw[$], tr_mw[$], tr_ill[$], tr_adr[$];
  logic [1:0] tr_res[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      outs_t a;
      a = {bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
           bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl,
           bus.IllegalInstr};
      chk($sformatf("cycle ins=%h step=%0d", cur_ins, cur_step), 32'(a), 32'(exp_o));
      tr_st.push_back(a.st);
      tr_pcw.push_back(a.pcw);
      tr_rw.push_back(a.rw);
      tr_mw.push_back(a.mw);
      tr_ill.push_back(a.ill);
      tr_adr.push_back(a.adr);
      tr_res.push_back(a.res);
    end
  end

  // ARM condition: evaluate the even code, odd codes are its inverse.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? ~r : r;
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Mux selects each phase shows, from the phase table.
  function automatic outs_t phase_outs(input int st, input logic [1:0] op);
    outs_t e;
    e = '0;
    e.st = 4'(st);
    e.imm = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    case (st)
      0, 1: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
      2, 7: e.srcb = 2'b01;
      3, 5: e.adr = 1'b1;
      4:    e.res = 2'b01;
      9:    begin e.srcb = 2'b01; e.res = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] xf, input int abort_at);
    logic [1:0] op;
    logic [3:0] cmd, rd;
    logic s, c, illegal, legal_dp, is_cmp, writes_reg;
    int seq[$];
    outs_t e;
    op  = ins[27:26];
    cmd = ins[24:21];
    s   = ins[20];
    rd  = ins[15:12];
    legal_dp = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    is_cmp   = (cmd == 4'b1010);
    illegal  = (op == 2'b11) || (op == 2'b00 && !legal_dp);
    c = cond_holds(ins[31:28], mflags);
    if (illegal) seq = '{0, 1};
    else if (op == 2'b00) seq = '{0, 1, ins[25] ? 7 : 6, 8};
    else if (op == 2'b01) seq = s ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
    else seq = '{0, 1, 9};
    writes_reg = (op == 2'b00 && !is_cmp) || (op == 2'b01 && s);
    model_len = seq.size();
    tr_st.delete(); tr_pcw.delete(); tr_rw.delete(); tr_mw.delete();
    tr_ill.delete(); tr_adr.delete(); tr_res.delete();
    for (int i = 0; i < seq.size(); i++) begin
      e = phase_outs(seq[i], op);
      e.irw = (i == 0);
      e.pcw = (i == 0);
      e.ill = illegal && (i == 1);
      if (i == seq.size() - 1 && i > 1) begin
        e.rw  = writes_reg && c;
        e.mw  = (op == 2'b01) && !s && c;
        e.pcw = c && (op == 2'b10 || (writes_reg && rd == 4'd15));
      end
      if (seq[i] == 6 || seq[i] == 7) e.aluc = alu_code(cmd);
      bus.Instr    = ins;
      bus.ALUFlags = (seq[i] == 6 || seq[i] == 7) ? xf : 4'($urandom);
      exp_o    = e;
      cur_ins  = ins;
      cur_step = i;
      check_en = 1'b1;
      if (i == abort_at) begin
        #2;
        chk("memwrite_before_reset", 32'(bus.MemWrite), 32'd1);
        check_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_reset_state", 32'(bus.State), 32'd0);
        chk("async_reset_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("async_reset_fetch_en", {30'd0, bus.PCWrite, bus.IRWrite}, 32'b11);
        mflags = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (op == 2'b00 && !illegal && c) begin
      if (s || is_cmp) mflags[3:2] = xf[3:2];
      if (is_cmp || (s && (cmd == 4'b0100 || cmd == 4'b0010))) mflags[1:0] = xf[1:0];
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      w[27:26] = 2'b00;
      case ($urandom_range(0, 4))
        0: w[24:21] = 4'b0100;
        1: w[24:21] = 4'b0010;
        2: w[24:21] = 4'b0000;
        3: w[24:21] = 4'b1100;
        default: w[24:21] = 4'b1010;
      endcase
    end else if (k <= 5) w[27:26] = 2'b01;
    else if (k <= 7) w[27:26] = 2'b10;
    else if (k == 8) w[27:26] = 2'b11;
    else w[27:26] = 2'b00;
    if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
    return w;
  endfunction

  initial begin
    reset = 1'b0;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    mflags = 4'b0000;
    @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.State), 32'd0);
    chk("reset_enables", {28'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite},
        32'b1100);
    chk("reset_illegal", 32'(bus.IllegalInstr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(32'hE0821003, 4'b1111, -1);
    chk("add_len", 32'(model_len), 32'd4);
    chk("add_states", {16'd0, tr_st[0], tr_st[1], tr_st[2], tr_st[3]}, 32'h0168);
    chk("add_regwrite", {28'd0, tr_rw[0], tr_rw[1], tr_rw[2], tr_rw[3]}, 32'b0001);
    chk("add_flags_model", 32'(mflags), 32'd0);

    run_instr(32'hE5910004, 4'b0000, -1);
    chk("ldr_len", 32'(model_len), 32'd5);
    chk("ldr_states", {12'd0, tr_st[0], tr_st[1], tr_st[2], tr_st[3], tr_st[4]}, 32'h01234);
    chk("ldr_memrd_adr", 32'(tr_adr[3]), 32'd1);
    chk("ldr_memwb", {29'd0, tr_res[4], tr_rw[4]}, 32'b011);

    run_instr(32'hE5810004, 4'b0000, -1);
    chk("str_len", 32'(model_len), 32'd4);
    chk("str_memwrite", {28'd0, tr_mw[0], tr_mw[1], tr_mw[2], tr_mw[3]}, 32'b0001);

    run_instr(32'hE1510001, 4'b0100, -1);
    chk("cmp_flags_model", 32'(mflags), 32'b0100);
    chk("cmp_no_regwrite", {28'd0, tr_rw[0], tr_rw[1], tr_rw[2], tr_rw[3]}, 32'd0);

    run_instr(32'h0A000002, 4'b0000, -1);
    chk("beq_taken_len", 32'(model_len), 32'd3);
    chk("beq_taken_pcwrite", {29'd0, tr_pcw[0], tr_pcw[1], tr_pcw[2]}, 32'b101);

    run_instr(32'hE082F003, 4'b0000, -1);
    chk("add_pc_writes", {30'd0, tr_rw[3], tr_pcw[3]}, 32'b11);

    run_instr(32'hFC000000, 4'b0000, -1);
    chk("illegal_len", 32'(model_len), 32'd2);
    chk("illegal_pulse", {30'd0, tr_ill[0], tr_ill[1]}, 32'b01);
    chk("illegal_states", {24'd0, tr_st[0], tr_st[1]}, 32'h01);

    // Set Z, then abort a store in MEMWR: reset must also clear Z.
    run_instr(32'hE1510001, 4'b0100, -1);
    run_instr(32'hE5810004, 4'b0000, 3);
    run_instr(32'h0A000002, 4'b0000, -1);
    chk("beq_after_reset_pcwrite", {29'd0, tr_pcw[0], tr_pcw[1], tr_pcw[2]}, 32'b100);
    chk("beq_after_reset_result", 32'(tr_res[2]), 32'd2);

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), 4'($urandom), -1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
